// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write controller and its timer.
// Covers frame layout, peripheral register map, controller states and pin decode.
package spi_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;

    localparam logic RW_WRITE = 1'b1;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD,
        ST_GAP
    } ctrl_state_t;

    typedef struct packed {
        logic sclk;
        logic mosi;
        logic cs_n;
    } spi_pins_t;

    localparam spi_pins_t PINS_IDLE = '{sclk: 1'b0, mosi: 1'b0, cs_n: 1'b1};

    // Counter width able to hold (max(a, b) - 1).
    function automatic int unsigned timer_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic spi_pins_t pins_for(ctrl_state_t st, logic bit_out);
        spi_pins_t p;
        case (st)
            ST_SETUP, ST_LOW, ST_HOLD: p = '{sclk: 1'b0, mosi: bit_out, cs_n: 1'b0};
            ST_HIGH:                   p = '{sclk: 1'b1, mosi: bit_out, cs_n: 1'b0};
            default:                   p = PINS_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/spi_controller_phase_timer.sv
// Loadable down-counter; phase_done is high on the last cycle of a loaded phase.
// Loading N-1 yields a phase exactly N cycles long.
module spi_phase_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         phase_done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign phase_done = (count_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI Mode 0 initiator sending 16-bit write frames {1, addr, data}, MSB first.
// Optional address range check enabled by defining SPI_CTRL_ADDR_CHECK_EN.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
`ifdef SPI_CTRL_ADDR_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] MAX_ADDRESS = 7'h04
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n
);

    localparam int unsigned TW = timer_width(CLK_DIV, CS_GAP);
    localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LOAD = TW'(CS_GAP - 1);

    ctrl_state_t        state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    spi_pins_t          pins_q, pins_d;

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          phase_done;
    logic          accept;
    logic          addr_ok;

    spi_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_val   (timer_val),
        .phase_done (phase_done)
    );

    assign accept = req_valid && (state_q == ST_IDLE);

`ifdef SPI_CTRL_ADDR_CHECK_EN
    logic err_q, err_d;
    assign addr_ok = (req_addr <= MAX_ADDRESS);
    assign err_d   = accept && !addr_ok;
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign addr_ok = 1'b1;
    assign err     = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        timer_load = 1'b0;
        timer_val  = DIV_LOAD;

        case (state_q)
            ST_IDLE: begin
                if (accept && addr_ok) begin
                    state_d    = ST_SETUP;
                    frame_d    = {RW_WRITE, req_addr, req_data};
                    bit_cnt_d  = 4'd15;
                    timer_load = 1'b1;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (phase_done) begin
                    state_d    = ST_HIGH;
                    timer_load = 1'b1;
                end
            end
            ST_HIGH: begin
                if (phase_done) begin
                    timer_load = 1'b1;
                    if (bit_cnt_q == 4'd0) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Shift here so mosi moves on the first LOW cycle, well away from sclk rise.
                        state_d   = ST_LOW;
                        bit_cnt_d = bit_cnt_q - 4'd1;
                        frame_d   = {frame_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (phase_done) begin
                    state_d    = ST_GAP;
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (phase_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pins are registered from the next state so the off-chip lines are glitch-free.
        pins_d = pins_for(state_d, frame_d[FRAME_W-1]);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            bit_cnt_q <= '0;
            pins_q    <= PINS_IDLE;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_cnt_q <= bit_cnt_d;
            pins_q    <= pins_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_GAP) && phase_done;
    assign sclk      = pins_q.sclk;
    assign mosi      = pins_q.mosi;
    assign cs_n      = pins_q.cs_n;

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench: a bus monitor decodes frames against a scoreboard queue
// and checks SPI timing; a second instance covers the minimum clock divider.
module tb_spi_controller;
    import spi_pkg::*;

    localparam int unsigned D_A      = 4;
    localparam int unsigned D_B      = 3;
    localparam int unsigned GAP      = 4;
    localparam int          MAX_WAIT = 3000;
`ifdef SPI_CTRL_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_ready, busy, done, err, sclk, mosi, cs_n;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       b_req_valid, b_req_ready, b_busy, b_done, b_err, b_sclk, b_mosi, b_cs_n;
    logic [6:0] b_req_addr;
    logic [7:0] b_req_data;

    spi_controller #(.CLK_DIV(D_A), .CS_GAP(GAP)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
        .err(err), .sclk(sclk), .mosi(mosi), .cs_n(cs_n)
    );

    spi_controller #(.CLK_DIV(D_B), .CS_GAP(GAP)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(b_req_addr), .req_data(b_req_data), .busy(b_busy), .done(b_done),
        .err(b_err), .sclk(b_sclk), .mosi(b_mosi), .cs_n(b_cs_n)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp_q[$];
    logic [7:0]  regs_a[0:7];
    logic [7:0]  regs_b[0:7];

    int cycle = 0;
    always @(posedge clk) cycle++;

    // Monitor state for instance A.
    logic        prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_mosi = 1'b0, prev_done = 1'b0;
    logic [15:0] sh = '0;
    int          rise_cnt = 0, cs_low_cnt = 0, cs_high_cnt = 0, last_gap = 0;
    int          done_cnt = 0, frames_done = 0;
    int          acc_cycle = 0, prev_acc_cycle = 0;
    bit          acc_flag = 1'b0, acc_bad = 1'b0, any_window = 1'b0, abort_ok = 1'b0;

    always @(negedge clk) begin
        if (cycle >= 2) begin
            check("busy_vs_ready", busy, !req_ready);
            check("err", err, acc_flag && acc_bad);
            if (acc_flag) begin
                if (acc_bad) begin
                    check("reject_cs_n", cs_n, 1'b1);
                    check("reject_ready", req_ready, 1'b1);
                end else begin
                    check("accept_cs_low", cs_n, 1'b0);
                    check("accept_busy", busy, 1'b1);
                    check("accept_not_ready", req_ready, 1'b0);
                end
            end
            acc_flag = 1'b0;
            if (!rst && req_valid && req_ready) begin
                acc_flag       = 1'b1;
                acc_bad        = ADDR_CHECK && (req_addr > 7'h04);
                prev_acc_cycle = acc_cycle;
                acc_cycle      = cycle;
            end

            if (!cs_n && prev_cs_n) begin
                if (any_window) check("cs_gap_min", cs_high_cnt >= GAP, 1'b1);
                last_gap   = cs_high_cnt;
                rise_cnt   = 0;
                cs_low_cnt = 0;
            end
            if (!cs_n && !prev_cs_n && mosi !== prev_mosi) check("mosi_change_sclk_low", sclk, 1'b0);
            if (sclk && !prev_sclk) begin
                check("sclk_rise_in_cs", cs_n, 1'b0);
                sh = {sh[14:0], mosi};
                rise_cnt++;
            end
            if (!cs_n) cs_low_cnt++;
            if (cs_n && !prev_cs_n) begin
                any_window = 1'b1;
                if (rise_cnt == 16) begin
                    check("cs_low_cycles", cs_low_cnt, 33 * D_A);
                    check("sb_not_empty", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) check("frame", sh, exp_q.pop_front());
                    if (sh[15] && sh[14:8] <= 7'h04) regs_a[sh[10:8]] = sh[7:0];
                    frames_done++;
                end else begin
                    check("abort_expected", abort_ok, 1'b1);
                    check("abort_rises", rise_cnt, 7);
                    abort_ok = 1'b0;
                end
                cs_high_cnt = 0;
            end
            if (cs_n) cs_high_cnt++;
            if (done) begin
                check("done_cs_high", cs_n, 1'b1);
                check("done_single_cycle", prev_done, 1'b0);
                done_cnt++;
            end
        end
        prev_sclk = sclk;
        prev_cs_n = cs_n;
        prev_mosi = mosi;
        prev_done = done;
    end

    // Lightweight recorder for instance B.
    logic        b_prev_sclk = 1'b0, b_prev_cs_n = 1'b1;
    logic [15:0] b_sh = '0, b_frame_last = '0;
    int          b_rises = 0, b_cs_low = 0, b_cs_low_last = 0, b_rises_last = 0, b_frames = 0;

    always @(negedge clk) begin
        if (cycle >= 2) begin
            if (!b_cs_n && b_prev_cs_n) begin
                b_rises  = 0;
                b_cs_low = 0;
            end
            if (b_sclk && !b_prev_sclk) begin
                b_sh = {b_sh[14:0], b_mosi};
                b_rises++;
            end
            if (!b_cs_n) b_cs_low++;
            if (b_cs_n && !b_prev_cs_n) begin
                b_cs_low_last = b_cs_low;
                b_frame_last  = b_sh;
                b_rises_last  = b_rises;
                if (b_rises == 16 && b_sh[15] && b_sh[14:8] <= 7'h04) regs_b[b_sh[10:8]] = b_sh[7:0];
                b_frames++;
            end
        end
        b_prev_sclk = b_sclk;
        b_prev_cs_n = b_cs_n;
    end

    task automatic send(input logic [6:0] a, input logic [7:0] d, input bit hold_valid,
                        input bit expect_tx);
        int n;
        bit acc;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        if (expect_tx) exp_q.push_back({RW_WRITE, a, d});
        n = 0;
        forever begin
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
            if (acc || n >= MAX_WAIT) break;
        end
        check("accept_timeout", acc, 1'b1);
        if (!hold_valid) req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("frames_completed", done_cnt, target);
    endtask

    initial begin
        int  n;
        int  exp_done;
        bit  acc;
        bit  hold;
        for (int i = 0; i < 8; i++) begin
            regs_a[i] = 8'h00;
            regs_b[i] = 8'h00;
        end
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_data = '0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_data = '0;
        exp_done = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_cs_n", cs_n, 1'b1);
        @(posedge clk); #1;

        // Single write to the PWM duty register.
        send(REG_PWM_DUTY, 8'hA5, 1'b0, 1'b1);
        exp_done++;
        wait_done(exp_done);
        check("pwm_duty_reg", regs_a[4], 8'hA5);

        // Back-to-back writes with valid held through done.
        send(REG_EN_OUT_7_0, 8'hFF, 1'b1, 1'b1);
        send(REG_EN_OUT_15_8, 8'h0F, 1'b0, 1'b1);
        exp_done += 2;
        wait_done(exp_done);
        check("b2b_period", acc_cycle - prev_acc_cycle, 1 + 33 * D_A + GAP);
        check("b2b_cs_high", last_gap, GAP + 1);
        check("en_out_7_0", regs_a[0], 8'hFF);
        check("en_out_15_8", regs_a[1], 8'h0F);

        // Reset in the middle of a frame.
        send(REG_EN_PWM_7_0, 8'h11, 1'b0, 1'b1);
        exp_done++;
        wait_done(exp_done);
        abort_ok = 1'b1;
        send(REG_EN_PWM_7_0, 8'h3C, 1'b0, 1'b0);
        n = 0;
        while (rise_cnt != 7 && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("abort_point_reached", rise_cnt, 7);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_sclk", sclk, 1'b0);
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_mosi", mosi, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_consumed", abort_ok, 1'b0);
        check("abort_reg_kept", regs_a[2], 8'h11);

        // Address beyond the register map.
        if (ADDR_CHECK) begin
            send(7'h05, 8'h77, 1'b0, 1'b0);
            @(negedge clk);
            check("reject_err_pulse", err, 1'b1);
            @(negedge clk);
            check("reject_err_clear", err, 1'b0);
            repeat (20) @(posedge clk);
            #1;
            check("reject_no_done", done_cnt, exp_done);
            check("reject_cs_idle", cs_n, 1'b1);
        end else begin
            send(7'h05, 8'h77, 1'b0, 1'b1);
            exp_done++;
            wait_done(exp_done);
        end

        // Random writes, some back-to-back.
        for (int i = 0; i < 20; i++) begin
            hold = (i != 19) && ($urandom_range(0, 1) == 1);
            send(7'($urandom_range(0, 4)), 8'($urandom), hold, 1'b1);
            exp_done++;
        end
        wait_done(exp_done);

        // Minimum divider instance.
        b_req_valid = 1'b1;
        b_req_addr  = REG_EN_PWM_15_8;
        b_req_data  = 8'h5A;
        n = 0;
        forever begin
            acc = b_req_ready;
            @(posedge clk);
            #1;
            n++;
            if (acc || n >= MAX_WAIT) break;
        end
        check("b_accept", acc, 1'b1);
        b_req_valid = 1'b0;
        n = 0;
        while (b_frames == 0 && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b_frame_seen", b_frames, 1);
        check("b_cs_low_cycles", b_cs_low_last, 33 * D_B);
        check("b_rises", b_rises_last, 16);
        check("b_frame", b_frame_last, 16'h835A);
        check("b_en_pwm_15_8", regs_b[3], 8'h5A);

        repeat (5) @(posedge clk);
        #1;
        check("done_total", done_cnt, exp_done);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI Mode 0 controller (initiator) that drives the write-only register interface of the project's SPI peripheral.
- Accepts one register-write request at a time over a valid/ready handshake and serialises it as a 16-bit frame, MSB first: {1'b1 (write), addr[6:0], data[7:0]}.
- Generates sclk, mosi and cs_n from the system clock. Used by on-chip sequencers and the loopback test harness to program the peripheral.

Parameters:
- CLK_DIV, 4: sclk half-period in clk cycles; legal range >= 3, because the peripheral samples through a 2-FF synchroniser.
- CS_GAP, 4: clk cycles cs_n is held high between frames; minimum 4.
- MAX_ADDRESS, 7'h04: highest valid register address; used only with ADDR_CHECK_EN.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  write request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  7  register address.
- req_data  in  8  register data.
- busy  out  1  high from the cycle after accept until return to IDLE.
- done  out  1  one-cycle pulse when a frame has fully completed (last GAP cycle).
- err  out  1  one-cycle pulse for a rejected request; tied 0 without ADDR_CHECK_EN.
- sclk  out  1  SPI clock; idles low.
- mosi  out  1  SPI data out.
- cs_n  out  1  SPI chip select, active low.

Behaviour:
- Reset is synchronous and active-high, on a single clock, clk.
- Reset values: state=IDLE, req_ready=1, busy=0, done=0, err=0, sclk=0, mosi=0, cs_n=1, bit counter=0, phase counter=0.
- Reset mid-frame: at the next edge all outputs return to reset values and the frame is abandoned. The peripheral discards partial frames when cs_n rises.
- Handshake: a request is accepted when req_valid && req_ready in IDLE. Frame {1,addr,data} is latched that cycle. req_ready is low from the next cycle until IDLE is re-entered. Inputs are don't-care while req_ready is low.
- States: IDLE -> SETUP -> HIGH <-> LOW -> HOLD -> GAP -> IDLE.
  - SETUP, D=CLK_DIV cycles: cs_n=0, sclk=0, mosi=frame[15].
  - HIGH, D cycles: sclk=1, mosi stable. The peripheral samples on the rising edge.
  - LOW, D cycles: sclk=0. mosi shifts to the next bit on the first LOW cycle. LOW is entered only if bits remain.
  - After the 16th HIGH phase go to HOLD, D cycles: sclk=0, cs_n=0.
  - GAP, CS_GAP cycles: cs_n=1, mosi=0. done pulses on the last GAP cycle; IDLE follows.
- Timing totals: cs_n low for exactly 33*D cycles; exactly 16 sclk rising edges per frame.
- Accept to first cs_n low: 1 cycle.
- Back-to-back: a request held valid during done is accepted in the first IDLE cycle, giving a minimum frame period of 1+33*D+CS_GAP cycles.
- Counters: phase counter width $clog2(CLK_DIV); bit counter 4 bits, counting 15 down to 0 with no wrap. The transition out of the final HIGH phase is taken on bit counter == 0.

Optional Feature:
- Macro: SPI_CTRL_ADDR_CHECK_EN.
- Defined: a request with addr > MAX_ADDRESS is still accepted, but no frame is sent. err pulses on the cycle after accept, done does not pulse, cs_n stays 1, and req_ready returns high 1 cycle after accept.
- Undefined: every address is transmitted and err is constant 0.

Decomposition:
- Package spi_pkg:
  - FRAME_W=16, ADDR_W=7, DATA_W=8.
  - RW_WRITE=1'b1.
  - Register address constants REG_EN_OUT_7_0=0x00 through REG_PWM_DUTY=0x04.
  - Controller state enum.
- Sub-module spi_phase_timer: a loadable down-counter that produces a phase_done strobe every CLK_DIV or CS_GAP cycles. The FSM and shift register stay in spi_controller.

Test Plan:
- Reset, then addr=0x04, data=0xA5 with CLK_DIV=4 -> frame 0x84A5 decoded on the sclk rising edges, cs_n low for 132 cycles, done 1 pulse, peripheral pwm_duty_cycle=0xA5.
- Back-to-back writes 0x00/0xFF and 0x01/0x0F held valid -> second accept in the IDLE cycle after done, cs_n high >= CS_GAP cycles, en_reg_out_7_0=0xFF and en_reg_out_15_8=0x0F.
- rst asserted after the 7th sclk rising edge of 0x02/0x3C -> next cycle cs_n=1, sclk=0, req_ready=1, and the peripheral register keeps its old value.
- With SPI_CTRL_ADDR_CHECK_EN: addr=0x05 -> err pulse 1 cycle after accept, no cs_n activity, done never asserted. Without the macro: frame 0x85xx is sent.
- Monitor across 20 random writes: mosi changes only while sclk=0, exactly 16 rising edges per cs_n window, busy matches the non-IDLE state.
- CLK_DIV=3 with addr=0x03, data=0x5A -> cs_n low for 99 cycles, and the peripheral captures en_reg_pwm_15_8=0x5A.
